microprogram_sequencer: RTL and testbench
=========================================

Name: microprogram_sequencer

Overview:
Microprogrammed controller for the X1/X2/X3 → Z1/Z2/Z3 sequential machines in this design. It holds a writable control store and steps a micro-PC through it. Each microword drives Z1..Z3 and may branch, call or return, conditioned on one of X1..X3. A Start/Busy/Done handshake lets a host launch a microprogram and detect its completion.

Parameters:
ADDR_W, 4, micro-PC and control-store address width; depth = 2**ADDR_W
START_ADDR, 0, micro-PC value loaded on Start

Ports:
Clk  input  1  clock; all state changes on the rising edge
Rst  input  1  synchronous, active-high reset
Start  input  1  launch request; sampled only in IDLE
X1  input  1  test input, select code 1
X2  input  1  test input, select code 2
X3  input  1  test input, select code 3
Prog_We  input  1  control-store write enable; honoured only in IDLE
Prog_Addr  input  ADDR_W  control-store write address
Prog_Data  input  ADDR_W+8  microword to write
Z1  output  1  control output, microword bit 2, registered
Z2  output  1  control output, microword bit 1, registered
Z3  output  1  control output, microword bit 0, registered
Busy  output  1  high while in RUN
Done  output  1  one-cycle pulse when the program ends
Err  output  1  sticky flag: CALL issued while the return register was already valid

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is synchronous and active-high.
- Microword layout (UW = ADDR_W+8, MSB first):
  - OP[UW-1:UW-2]: 0 CONT, 1 BR, 2 CALL, 3 RET
  - TEST[UW-3:UW-4]: 0 always, 1 X1, 2 X2, 3 X3
  - POL[UW-5]: 1 inverts the tested input
  - ADDR[UW-6:3]: target address
  - Z[2:0]: Z1 = bit 2, Z2 = bit 1, Z3 = bit 0
- Condition: cond = 1 when TEST = 0; otherwise cond = Xsel XOR POL. Xsel is sampled at the executing edge.
- Reset values:
  - state IDLE, uPC = 0, Z1..Z3 = 0
  - Busy = 0, Done = 0, Err = 0
  - return-register valid bit (RV) = 0; return address = 0
  - Control-store contents are NOT reset.
  - Rst has priority over every other input, including mid-RUN.
- IDLE:
  - Z1..Z3 = 0.
  - Prog_We = 1 writes Prog_Data to rom[Prog_Addr]; visible from the next cycle.
  - Start = 1: state becomes RUN, uPC becomes START_ADDR, RV and Err clear, Busy = 1 from the next cycle.
  - Start and Prog_We in the same cycle: both take effect.
- RUN: one microword per cycle, read combinationally from rom[uPC] (uPC = a). At each edge:
  - Z1..Z3 load W.Z, so outputs show instruction a one cycle after it is fetched.
  - CONT, or any OP with cond = 0: uPC becomes a+1, wrapping modulo 2**ADDR_W (15 → 0 for ADDR_W = 4).
  - BR with cond = 1: uPC becomes ADDR.
  - CALL with cond = 1: return address becomes a+1 (wrapped), RV = 1, uPC becomes ADDR. If RV was already 1, Err is set and the return address is overwritten.
  - RET with cond = 1 and RV = 1: uPC becomes the return address, RV = 0.
  - RET with cond = 1 and RV = 0 (program end): state becomes IDLE, Z1..Z3 = 0 (the RET's Z field is ignored), Done = 1 for exactly one cycle, Busy = 0.
  - Start and Prog_We are ignored.
- Err stays set until Rst or the next accepted Start.
- Latency: from the Start edge, the Z field of the first microword appears after the second edge.

Decomposition:
- Package uprog_pkg:
  - OP_CONT/OP_BR/OP_CALL/OP_RET and TST_NONE/TST_X1/TST_X2/TST_X3 constants
  - IDLE/RUN state encoding
  - field-offset constants derived from ADDR_W
- Sub-module microprogram_rom: 2**ADDR_W × UW register array with one synchronous write port and one asynchronous read port, no reset.

Test Plan:
- Reset: Rst = 1 for 2 cycles with Start = 1 → Z = 000, Busy = 0, Done = 0, Err = 0; Start is not accepted while Rst = 1.
- Linear run: rom[0] = CONT Z=100, rom[1] = CONT Z=010, rom[2] = RET TEST=0 Z=001; pulse Start → Z = 100, then 010; Done = 1 for one cycle with Busy = 0 and Z = 000.
- Branch: rom[0] = BR TEST=2 POL=0 ADDR=5 Z=001, rom[5] = RET Z=110, rom[1] = RET Z=011.
  - X2 = 1 → executes 0 then 5; Done after 2 instructions.
  - X2 = 0 → executes 0 then 1.
  - POL = 1 reverses both outcomes.
- Call/return: rom[0] = CALL ADDR=8, rom[8] = CONT Z=111, rom[9] = RET, rom[1] = RET → execution order 0, 8, 9, 1, then Done, Err = 0. Changing rom[8] to CALL ADDR=12 (rom[12] = RET) → Err = 1, still set after Done, cleared by the next Start.
- Wrap: START_ADDR = 14, rom[14] = CONT Z=101, rom[15] = CONT Z=011, rom[0] = RET → Z = 101, then 011, then Done.
- Mid-run: assert Prog_We to rom[1] during RUN → contents unchanged; assert Rst during RUN → next cycle IDLE, all outputs 0, and no Done pulse.

Source files
------------

// File: rtl/uprog_pkg.sv
// Shared encodings for the microprogram sequencer: opcodes, test selects,
// controller states and microword field offsets as functions of ADDR_W.
package uprog_pkg;

    localparam logic [1:0] OP_CONT = 2'd0;
    localparam logic [1:0] OP_BR   = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [1:0] TST_NONE = 2'd0;
    localparam logic [1:0] TST_X1   = 2'd1;
    localparam logic [1:0] TST_X2   = 2'd2;
    localparam logic [1:0] TST_X3   = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Microword is {OP[2], TEST[2], POL, ADDR[ADDR_W], Z[3]}, MSB first.
    localparam int Z_LSB    = 0;
    localparam int ADDR_LSB = 3;

    function automatic int uw_width(input int aw);
        return aw + 8;
    endfunction

    function automatic int pol_bit(input int aw);
        return aw + 3;
    endfunction

    function automatic int test_lsb(input int aw);
        return aw + 4;
    endfunction

    function automatic int op_lsb(input int aw);
        return aw + 6;
    endfunction

endpackage

// File: rtl/microprogram_rom.sv
// Writable control store: one synchronous write port and one asynchronous
// read port so the sequencer can fetch and execute in the same cycle.
module microprogram_rom #(
    parameter int ADDR_W = 4,
    parameter int UW     = ADDR_W + 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [UW-1:0]     wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [UW-1:0]     rd_data
);

    logic [UW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/microprogram_sequencer.sv
// Micro-PC sequencer: executes one microword per cycle from the control store,
// with conditional branch, single-level call/return and a Start/Busy/Done handshake.
module microprogram_sequencer
    import uprog_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int START_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              X1,
    input  logic              X2,
    input  logic              X3,
    input  logic              Prog_We,
    input  logic [ADDR_W-1:0] Prog_Addr,
    input  logic [ADDR_W+7:0] Prog_Data,
    output logic              Z1,
    output logic              Z2,
    output logic              Z3,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int UW       = uw_width(ADDR_W);
    localparam int OP_LSB   = op_lsb(ADDR_W);
    localparam int TEST_LSB = test_lsb(ADDR_W);
    localparam int POL_BIT  = pol_bit(ADDR_W);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] upc_reg, upc_next;
    logic [ADDR_W-1:0] ret_reg, ret_next;
    logic              rv_reg, rv_next;
    logic [2:0]        z_reg, z_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic [UW-1:0]     word;
    logic [1:0]        w_op;
    logic [1:0]        w_test;
    logic              w_pol;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_z;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] start_pc;
    logic              xsel;
    logic              cond;
    logic              rom_we;

    assign rom_we = Prog_We && (state_reg == IDLE);

    microprogram_rom #(
        .ADDR_W (ADDR_W),
        .UW     (UW)
    ) u_rom (
        .clk     (Clk),
        .we      (rom_we),
        .wr_addr (Prog_Addr),
        .wr_data (Prog_Data),
        .rd_addr (upc_reg),
        .rd_data (word)
    );

    assign w_op     = word[OP_LSB +: 2];
    assign w_test   = word[TEST_LSB +: 2];
    assign w_pol    = word[POL_BIT];
    assign w_addr   = word[ADDR_LSB +: ADDR_W];
    assign w_z      = word[Z_LSB +: 3];
    assign upc_inc  = upc_reg + ADDR_W'(1);
    assign start_pc = ADDR_W'(START_ADDR);

    always_comb begin
        xsel = 1'b0;
        case (w_test)
            TST_X1:  xsel = X1;
            TST_X2:  xsel = X2;
            TST_X3:  xsel = X3;
            default: xsel = 1'b0;
        endcase
    end

    assign cond = (w_test == TST_NONE) ? 1'b1 : (xsel ^ w_pol);

    always_comb begin
        state_next = state_reg;
        upc_next   = upc_reg;
        ret_next   = ret_reg;
        rv_next    = rv_reg;
        z_next     = z_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                z_next = 3'b000;
                if (Start) begin
                    state_next = RUN;
                    upc_next   = start_pc;
                    rv_next    = 1'b0;
                    err_next   = 1'b0;
                end
            end
            RUN: begin
                z_next   = w_z;
                upc_next = upc_inc;
                if (cond) begin
                    case (w_op)
                        OP_BR: upc_next = w_addr;
                        OP_CALL: begin
                            // Only one return level: a nested call clobbers it and is flagged.
                            if (rv_reg) begin
                                err_next = 1'b1;
                            end
                            ret_next = upc_inc;
                            rv_next  = 1'b1;
                            upc_next = w_addr;
                        end
                        OP_RET: begin
                            if (rv_reg) begin
                                upc_next = ret_reg;
                                rv_next  = 1'b0;
                            end else begin
                                state_next = IDLE;
                                z_next     = 3'b000;
                                done_next  = 1'b1;
                            end
                        end
                        default: upc_next = upc_inc;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
            upc_reg   <= '0;
            ret_reg   <= '0;
            rv_reg    <= 1'b0;
            z_reg     <= 3'b000;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            upc_reg   <= upc_next;
            ret_reg   <= ret_next;
            rv_reg    <= rv_next;
            z_reg     <= z_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign Z1   = z_reg[2];
    assign Z2   = z_reg[1];
    assign Z3   = z_reg[0];
    assign Busy = (state_reg == RUN);
    assign Done = done_reg;
    assign Err  = err_reg;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Randomized bench: two sequencers (start addresses 0 and 14) share the host
// interface and are compared every cycle against a microprogram interpreter.
module tb_microprogram_sequencer;

    localparam int LIMIT = 24;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        X1 = 1'b0;
    logic        X2 = 1'b0;
    logic        X3 = 1'b0;
    logic        Prog_We = 1'b0;
    logic [3:0]  Prog_Addr = '0;
    logic [11:0] Prog_Data = '0;

    logic z1 [2];
    logic z2 [2];
    logic z3 [2];
    logic busy [2];
    logic done [2];
    logic err [2];

    int mrom [16];
    int exp_z    [2][LIMIT];
    int exp_busy [2][LIMIT];
    int exp_done [2][LIMIT];
    int exp_err  [2][LIMIT];
    int exp_len  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    microprogram_sequencer #(.ADDR_W(4), .START_ADDR(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .X1(X1), .X2(X2), .X3(X3),
        .Prog_We(Prog_We), .Prog_Addr(Prog_Addr), .Prog_Data(Prog_Data),
        .Z1(z1[0]), .Z2(z2[0]), .Z3(z3[0]), .Busy(busy[0]), .Done(done[0]), .Err(err[0])
    );

    microprogram_sequencer #(.ADDR_W(4), .START_ADDR(14)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .X1(X1), .X2(X2), .X3(X3),
        .Prog_We(Prog_We), .Prog_Addr(Prog_Addr), .Prog_Data(Prog_Data),
        .Z1(z1[1]), .Z2(z2[1]), .Z3(z3[1]), .Busy(busy[1]), .Done(done[1]), .Err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int mw(input int op, input int test, input int pol,
                              input int addr, input int z);
        return op * 1024 + test * 256 + pol * 128 + addr * 8 + z;
    endfunction

    task automatic wr(input int a, input int d);
        logic [3:0]  a4;
        logic [11:0] d12;
        a4 = a[3:0];
        d12 = d[11:0];
        Prog_We = 1'b1;
        Prog_Addr = a4;
        Prog_Data = d12;
        @(posedge Clk);
        #1;
        Prog_We = 1'b0;
        mrom[a] = d;
    endtask

    // Interpret the program from start address sa with constant test inputs;
    // entry c is what the outputs should show c edges after the Start edge.
    task automatic model(input int d, input int sa, input int x1, input int x2, input int x3);
        int pc, rv, ra, er, running, w, op, test, pol, addr, z, x, cond, nxt;
        pc = sa; rv = 0; ra = 0; er = 0; running = 1;
        exp_len[d] = LIMIT;
        exp_z[d][0] = 0; exp_busy[d][0] = 1; exp_done[d][0] = 0; exp_err[d][0] = 0;
        for (int c = 1; c < LIMIT; c++) begin
            exp_z[d][c] = 0; exp_busy[d][c] = 0; exp_done[d][c] = 0;
            if (running != 0) begin
                w = mrom[pc];
                op = w / 1024;
                test = (w / 256) % 4;
                pol = (w / 128) % 2;
                addr = (w / 8) % 16;
                z = w % 8;
                x = (test == 1) ? x1 : (test == 2) ? x2 : x3;
                cond = (test == 0) ? 1 : (x + pol) % 2;
                nxt = (pc + 1) % 16;
                exp_busy[d][c] = 1;
                exp_z[d][c] = z;
                if (cond == 0 || op == 0) begin
                    pc = nxt;
                end else if (op == 1) begin
                    pc = addr;
                end else if (op == 2) begin
                    if (rv != 0) er = 1;
                    ra = nxt; rv = 1; pc = addr;
                end else if (rv != 0) begin
                    pc = ra; rv = 0;
                end else begin
                    running = 0;
                    exp_busy[d][c] = 0;
                    exp_z[d][c] = 0;
                    exp_done[d][c] = 1;
                    exp_len[d] = c;
                end
            end
            exp_err[d][c] = er;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d z", tag, d), {z1[d], z2[d], z3[d]}, 0);
            chk($sformatf("%s d%0d busy", tag, d), busy[d], 0);
            chk($sformatf("%s d%0d done", tag, d), done[d], 0);
            chk($sformatf("%s d%0d err", tag, d), err[d], 0);
        end
    endtask

    // noise: inject Start/Prog_We while both machines run, and a write alongside Start.
    task automatic run(input string name, input int x1, input int x2, input int x3,
                       input int noise, input int rst_at);
        int a, dv, cut;
        logic [3:0] a4;
        logic [11:0] d12;
        cut = 0;
        X1 = x1[0]; X2 = x2[0]; X3 = x3[0];
        Start = 1'b1;
        if (noise != 0) begin
            a = $urandom_range(0, 15);
            dv = $urandom_range(0, 4095);
            a4 = a[3:0]; d12 = dv[11:0];
            Prog_We = 1'b1; Prog_Addr = a4; Prog_Data = d12;
            mrom[a] = dv;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Prog_We = 1'b0;
        model(0, 0, x1, x2, x3);
        model(1, 14, x1, x2, x3);
        for (int c = 0; c < LIMIT; c++) begin
            if (c == rst_at) begin
                cut = 1;
                break;
            end
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s d%0d c%0d z", name, d, c), {z1[d], z2[d], z3[d]}, exp_z[d][c]);
                chk($sformatf("%s d%0d c%0d busy", name, d, c), busy[d], exp_busy[d][c]);
                chk($sformatf("%s d%0d c%0d done", name, d, c), done[d], exp_done[d][c]);
                chk($sformatf("%s d%0d c%0d err", name, d, c), err[d], exp_err[d][c]);
            end
            if (noise != 0 && exp_busy[0][c] != 0 && exp_busy[1][c] != 0 && $urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(0, 15);
                dv = $urandom_range(0, 4095);
                a4 = a[3:0]; d12 = dv[11:0];
                Start = 1'b1; Prog_We = 1'b1; Prog_Addr = a4; Prog_Data = d12;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0;
            Prog_We = 1'b0;
        end
        if (cut != 0 || exp_busy[0][LIMIT-1] != 0 || exp_busy[1][LIMIT-1] != 0) begin
            Rst = 1'b1;
            @(posedge Clk);
            #1;
            Rst = 1'b0;
            check_zero($sformatf("%s rst", name));
            cut = 1;
        end
        $display("run %s x=%0d%0d%0d len0=%0d len1=%0d reset=%0d", name, x1, x2, x3,
                 exp_len[0], exp_len[1], cut);
    endtask

    initial begin
        Rst = 1'b1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        check_zero("reset1");
        @(posedge Clk);
        #1;
        check_zero("reset2");
        Rst = 1'b0;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        check_zero("post_reset");

        for (int i = 0; i < 16; i++) wr(i, mw(3, 0, 0, 0, 0));

        wr(0, mw(0, 0, 0, 0, 4));
        wr(1, mw(0, 0, 0, 0, 2));
        wr(2, mw(3, 0, 0, 0, 1));
        run("linear", 0, 0, 0, 0, LIMIT);

        wr(0, mw(1, 2, 0, 5, 1));
        wr(5, mw(3, 0, 0, 0, 6));
        wr(1, mw(3, 0, 0, 0, 3));
        run("br_x2_1", 0, 1, 0, 0, LIMIT);
        run("br_x2_0", 1, 0, 1, 0, LIMIT);
        wr(0, mw(1, 2, 1, 5, 1));
        run("brpol_x2_1", 0, 1, 0, 0, LIMIT);
        run("brpol_x2_0", 0, 0, 0, 0, LIMIT);

        wr(0, mw(2, 0, 0, 8, 0));
        wr(8, mw(0, 0, 0, 0, 7));
        wr(9, mw(3, 0, 0, 0, 0));
        wr(1, mw(3, 0, 0, 0, 0));
        run("call", 0, 0, 0, 0, LIMIT);
        wr(8, mw(2, 0, 0, 12, 0));
        wr(12, mw(3, 0, 0, 0, 0));
        run("call_nested", 0, 0, 0, 0, LIMIT);
        run("call_nested_again", 0, 0, 0, 0, LIMIT);

        wr(14, mw(0, 0, 0, 0, 5));
        wr(15, mw(0, 0, 0, 0, 3));
        wr(0, mw(3, 0, 0, 0, 0));
        run("wrap", 0, 0, 0, 0, LIMIT);

        wr(0, mw(0, 0, 0, 0, 6));
        wr(1, mw(1, 0, 0, 0, 2));
        run("midrun_we", 0, 0, 0, 1, LIMIT);
        run("midrun_rst", 0, 0, 0, 1, 3);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 16; i++) begin
                wr(i, mw($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                         $urandom_range(0, 15), $urandom_range(0, 7)));
            end
            run($sformatf("rand%0d", r), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, LIMIT - 1) : LIMIT);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
